// File: rtl/farbborg_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : farbborg_scanner_if
//  Description : Framebuffer read-port bundle between the scan engine and the
//                1024-byte framebuffer (64-bit words, 7-bit word address,
//                data returned one clock after the address).
//                  ram_addr_o : 7-bit word address, driven by the scanner
//                  ram_data_i : 64-bit read data, driven by the framebuffer
//                  modport master : scanner side
//                  modport slave  : framebuffer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface farbborg_scanner_if;
    logic [6:0]  ram_addr_o;
    logic [63:0] ram_data_i;

    modport master (output ram_addr_o, input  ram_data_i);
    modport slave  (input  ram_addr_o, output ram_data_i);
endinterface
`default_nettype wire

// File: rtl/farbborg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : farbborg_scanner
//  Description : Display scan engine for the wb_farbborg LED matrix. Reads a
//                row of intensity bytes from the framebuffer, turns each byte
//                into one on/off bit by comparing it with a running PWM
//                counter, shifts the bits into the external column shift
//                registers, latches them and drives the row-select lines.
//  Ports       : clk_i    - system clock
//                rst_n_i  - synchronous active-low reset
//                enable_i - scan enable (sampled in IDLE and LATCH only)
//                fb       - framebuffer read port (master side)
//                sclk_o   - column shift clock (rising-edge sampled)
//                sdata_o  - column serial data
//                latch_o  - column latch strobe, 1-cycle pulse
//                oe_n_o   - column output enable, active low
//                row_o    - active row index
//                frame_o  - 1-cycle pulse on the last row-step of a frame
//  Options     : FARBBORG_SCAN_BLANK_EN - blank the columns during LATCH and
//                for 4 further cycles after each row change (anti-ghosting).
//  Revision    : 1.0 - initial release
// ============================================================================
module farbborg_scanner #(
    parameter int ROWS          = 16,
    parameter int WORDS_PER_ROW = 8,
    parameter int PWM_BITS      = 8,
    parameter int SCLK_DIV      = 2
) (
    input  wire logic           clk_i,
    input  wire logic           rst_n_i,
    input  wire logic           enable_i,
    farbborg_scanner_if.master  fb,
    output logic                sclk_o,
    output logic                sdata_o,
    output logic                latch_o,
    output logic                oe_n_o,
    output logic [3:0]          row_o,
    output logic                frame_o
);

    localparam int c_WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int c_DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [c_WORD_W-1:0] c_WORD_LAST = c_WORD_W'(WORDS_PER_ROW - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SCLK_DIV - 1);
    localparam logic [6:0]          c_ROW_LAST  = 7'(ROWS - 1);
    localparam logic [PWM_BITS-1:0] c_PWM_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t                 r_state;
    logic [6:0]             r_addr;
    logic [6:0]             r_row;
    logic [PWM_BITS-1:0]    r_pwm;
    logic [c_WORD_W-1:0]    r_word;
    logic [2:0]             r_bit;
    logic [c_DIV_W-1:0]     r_div;
    logic [7:0]             r_vec;      // remaining bits, MSB is the next one out
    logic                   r_sclk;
    logic                   r_sdata;
    logic                   r_latch;
    logic                   r_oe_n;
    logic [3:0]             r_row_o;
    logic                   r_frame;
`ifdef FARBBORG_SCAN_BLANK_EN
    logic [2:0]             r_blank;    // blanking cycles still to run after LATCH
    logic                   r_row_chg;  // the row being latched differs from row_o
`endif

    logic [7:0]             w_vec;

    function automatic logic [6:0] f_addr(input logic [6:0] row,
                                          input logic [c_WORD_W-1:0] word);
        return 7'(32'(row) * 32'(WORDS_PER_ROW) + 32'(word));
    endfunction

    // Channel is on when its intensity strictly exceeds the PWM count, so
    // 0 is never on and 255 is on for 255 of the 256 steps.
    for (genvar k = 0; k < 8; k++) begin : g_cmp
        assign w_vec[k] = ({{PWM_BITS{1'b0}}, fb.ram_data_i[8*k +: 8]} >
                           {8'h00, r_pwm});
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_row     <= '0;
            r_pwm     <= '0;
            r_word    <= '0;
            r_bit     <= '0;
            r_div     <= '0;
            r_vec     <= '0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_latch   <= 1'b0;
            r_oe_n    <= 1'b1;
            r_row_o   <= '0;
            r_frame   <= 1'b0;
`ifdef FARBBORG_SCAN_BLANK_EN
            r_blank   <= '0;
            r_row_chg <= 1'b0;
`endif
        end else begin
            r_latch <= 1'b0;
            r_frame <= 1'b0;
`ifdef FARBBORG_SCAN_BLANK_EN
            // Runs alongside FETCH/WAIT/SHIFT; LATCH and IDLE override below.
            if (r_blank != 3'd0) begin
                r_blank <= r_blank - 1'b1;
                r_oe_n  <= (r_blank != 3'd1);
            end
`endif
            case (r_state)
                S_IDLE: begin
                    r_oe_n <= 1'b1;
                    if (enable_i) begin
                        r_word  <= c_WORD_LAST;
                        r_addr  <= f_addr(r_row, c_WORD_LAST);
                        r_oe_n  <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_state <= S_WAIT;
                end

                // Read data is valid in this cycle (one clock after FETCH).
                S_WAIT: begin
                    r_sdata <= w_vec[7];
                    r_vec   <= {w_vec[6:0], 1'b0};
                    r_bit   <= 3'd7;
                    r_div   <= '0;
                    r_sclk  <= 1'b0;
                    r_state <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (r_div != c_DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling edge: data may change only now.
                            r_sclk <= 1'b0;
                            if (r_bit != 3'd0) begin
                                r_bit   <= r_bit - 1'b1;
                                r_sdata <= r_vec[7];
                                r_vec   <= {r_vec[6:0], 1'b0};
                            end else if (r_word != '0) begin
                                r_word  <= r_word - 1'b1;
                                r_addr  <= f_addr(r_row, r_word - 1'b1);
                                r_state <= S_FETCH;
                            end else begin
                                // Entering LATCH: all LATCH outputs are
                                // registered here so they appear in that cycle.
                                r_latch <= 1'b1;
                                r_row_o <= r_row[3:0];
                                r_pwm   <= r_pwm + 1'b1;
                                if (r_pwm == c_PWM_MAX) begin
                                    if (r_row == c_ROW_LAST) begin
                                        r_row   <= '0;
                                        r_frame <= 1'b1;
                                    end else begin
                                        r_row   <= r_row + 1'b1;
                                    end
                                end
`ifdef FARBBORG_SCAN_BLANK_EN
                                r_oe_n    <= 1'b1;
                                r_row_chg <= (r_row[3:0] != r_row_o);
`endif
                                r_state <= S_LATCH;
                            end
                        end
                    end
                end

                S_LATCH: begin
                    if (enable_i) begin
                        r_word  <= c_WORD_LAST;
                        r_addr  <= f_addr(r_row, c_WORD_LAST);
                        r_state <= S_FETCH;
`ifdef FARBBORG_SCAN_BLANK_EN
                        r_oe_n  <= r_row_chg;
                        r_blank <= r_row_chg ? 3'd4 : 3'd0;
`endif
                    end else begin
                        r_oe_n  <= 1'b1;
                        r_state <= S_IDLE;
`ifdef FARBBORG_SCAN_BLANK_EN
                        r_blank <= 3'd0;
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fb.ram_addr_o = r_addr;
    assign sclk_o        = r_sclk;
    assign sdata_o       = r_sdata;
    assign latch_o       = r_latch;
    assign oe_n_o        = r_oe_n;
    assign row_o         = r_row_o;
    assign frame_o       = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_farbborg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_farbborg_scanner
//  Description : Scoreboard bench for farbborg_scanner. A default-parameter
//                instance is fed from a framebuffer model; expected shifted
//                bits and latch results are queued when each row-step is
//                issued and popped by a monitor on every sclk_o rising edge
//                and every latch_o pulse. A second, small-PWM instance checks
//                frame timing, row wrap and the row-15 address range.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_farbborg_scanner;

`ifdef FARBBORG_SCAN_BLANK_EN
    localparam bit c_BLANK = 1'b1;
`else
    localparam bit c_BLANK = 1'b0;
`endif

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- default instance ----------------
    logic       rst_n_i, enable_i;
    logic       sclk_o, sdata_o, latch_o, oe_n_o, frame_o;
    logic [3:0] row_o;
    farbborg_scanner_if fb_if();

    farbborg_scanner u_dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .enable_i(enable_i),
        .fb      (fb_if),
        .sclk_o  (sclk_o),
        .sdata_o (sdata_o),
        .latch_o (latch_o),
        .oe_n_o  (oe_n_o),
        .row_o   (row_o),
        .frame_o (frame_o)
    );

    // ---------------- small instance: 1-bit PWM, SCLK_DIV=1 ----------------
    logic       m_rst_n, m_enable;
    logic       m_sclk, m_sdata, m_latch, m_oe_n, m_frame;
    logic [3:0] m_row;
    farbborg_scanner_if mini_if();
    assign mini_if.ram_data_i = 64'h0;

    farbborg_scanner #(
        .ROWS(16), .WORDS_PER_ROW(8), .PWM_BITS(1), .SCLK_DIV(1)
    ) u_mini (
        .clk_i   (clk_i),
        .rst_n_i (m_rst_n),
        .enable_i(m_enable),
        .fb      (mini_if),
        .sclk_o  (m_sclk),
        .sdata_o (m_sdata),
        .latch_o (m_latch),
        .oe_n_o  (m_oe_n),
        .row_o   (m_row),
        .frame_o (m_frame)
    );

    // ---------------- framebuffer model ----------------
    // phase 0: all zero. phase 1: row 0 has only word0/byte0 = 0xFF;
    // other rows have word7/byte7 = 0x01 and word4/byte2 = 0x80.
    int mem_phase = 0;

    function automatic logic [7:0] fb_byte(input int phase, input int row,
                                           input int w, input int b);
        if (phase == 0) return 8'h00;
        if (row == 0)   return (w == 0 && b == 0) ? 8'hFF : 8'h00;
        if (w == 7 && b == 7) return 8'h01;
        if (w == 4 && b == 2) return 8'h80;
        return 8'h00;
    endfunction

    function automatic logic [63:0] fb_word(input int phase, input logic [6:0] addr);
        logic [63:0] d;
        d = '0;
        for (int b = 0; b < 8; b++)
            d[8*b +: 8] = fb_byte(phase, int'(addr) / 8, int'(addr) % 8, b);
        return d;
    endfunction

    always @(posedge clk_i) fb_if.ram_data_i <= fb_word(mem_phase, fb_if.ram_addr_o);

    // ---------------- scoreboard ----------------
    typedef struct { bit v; int step; int idx; } exp_bit_t;
    typedef struct { logic [3:0] row; logic frame; } exp_latch_t;
    exp_bit_t   exp_bits[$];
    exp_latch_t exp_latch[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Queue the 64 bits (word 7 byte 7 first, word 0 byte 0 last) and the
    // latch result for row-step k of the given framebuffer phase.
    task automatic push_step(input int phase, input int k);
        int p, r, idx;
        exp_latch_t l;
        p   = k % 256;
        r   = (k / 256) % 16;
        idx = 0;
        for (int w = 7; w >= 0; w--) begin
            for (int b = 7; b >= 0; b--) begin
                exp_bit_t e;
                e.v    = (int'(fb_byte(phase, r, w, b)) > p);
                e.step = k;
                e.idx  = idx;
                exp_bits.push_back(e);
                idx++;
            end
        end
        l.row   = 4'(r);
        l.frame = 1'b0;
        exp_latch.push_back(l);
    endtask

    // Monitor for the default instance.
    logic prev_sclk = 1'b0;
    always @(negedge clk_i) begin
        if (sclk_o === 1'b1 && prev_sclk === 1'b0) begin
            if (exp_bits.size() == 0) begin
                fail_now("unexpected sclk_o rising edge");
            end else begin
                exp_bit_t e;
                e = exp_bits.pop_front();
                check($sformatf("sdata step%0d bit%0d", e.step, e.idx), sdata_o, e.v);
            end
        end
        prev_sclk = sclk_o;
        if (latch_o === 1'b1) begin
            if (exp_latch.size() == 0) begin
                fail_now("unexpected latch_o pulse");
            end else begin
                exp_latch_t l;
                l = exp_latch.pop_front();
                check("latch row_o", row_o, l.row);
                check("latch frame_o", frame_o, l.frame);
            end
        end else if (frame_o !== 1'b0) begin
            fail_now("frame_o outside latch");
        end
    end

    task automatic wait_latch(input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < bound) begin
            @(negedge clk_i);
            n++;
            if (latch_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("timeout waiting for latch_o");
            finish_tb();
        end
    endtask

    // {addr, sclk, sdata, latch, oe_n, row, frame} at reset values
    function automatic logic [15:0] out_vec();
        return {fb_if.ram_addr_o, sclk_o, sdata_o, latch_o, oe_n_o, row_o, frame_o};
    endfunction
    localparam logic [15:0] c_RST_VEC = {7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};

    // ---------------- small-instance checker ----------------
    bit mini_done = 1'b0;
    initial begin
        int latches, frames, amin, amax;
        bit collecting;
        m_rst_n  = 1'b0;
        m_enable = 1'b1;
        latches = 0; frames = 0; amin = 127; amax = 0; collecting = 1'b0;
        repeat (3) @(negedge clk_i);
        m_rst_n = 1'b1;
        for (int cyc = 0; cyc < 6000 && latches < 33; cyc++) begin
            @(negedge clk_i);
            if (collecting) begin
                if (int'(mini_if.ram_addr_o) < amin) amin = int'(mini_if.ram_addr_o);
                if (int'(mini_if.ram_addr_o) > amax) amax = int'(mini_if.ram_addr_o);
            end
            if (m_frame === 1'b1) frames++;
            if (m_latch === 1'b1) begin
                latches++;
                check($sformatf("mini row_o latch%0d", latches), m_row, ((latches - 1) / 2) % 16);
                check($sformatf("mini frame_o latch%0d", latches), m_frame, (latches == 32));
                if (latches == 30) collecting = 1'b1;
                if (latches == 32) collecting = 1'b0;
            end
        end
        check("mini latch count", latches, 33);
        check("mini frame pulses", frames, 1);
        check("mini row15 addr min", amin, 120);
        check("mini row15 addr max", amax, 127);
        mini_done = 1'b1;
    end

    // ---------------- main stimulus ----------------
    initial begin
        int n, spent;
        bit ok;
        rst_n_i  = 1'b0;
        enable_i = 1'b1;

        // Reset held 3 cycles with enable high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check($sformatf("reset outputs cycle%0d", i), out_vec(), c_RST_VEC);
        end

        // Phase A: all-zero framebuffer, one complete row-step.
        push_step(0, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("first FETCH ram_addr_o", fb_if.ram_addr_o, 7);
        check("oe_n_o after IDLE", oe_n_o, 0);
        wait_latch(300, n, ok);
        check("first latch cycle", n + 1, 273);

        // Reset in the middle of the next row-step: no latch may follow.
        push_step(0, 1);
        repeat (100) @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check("mid-op reset outputs", out_vec(), c_RST_VEC);
        exp_bits.delete();
        exp_latch.delete();
        mem_phase = 1;
        @(negedge clk_i);
        check("mid-op reset held outputs", out_vec(), c_RST_VEC);

        // Phase B: 258 row-steps; enable dropped mid-SHIFT in the last one.
        push_step(1, 0);
        rst_n_i = 1'b1;
        spent = 0;
        for (int k = 0; k < 258; k++) begin
            wait_latch(300, n, ok);
            check($sformatf("row-step length %0d", k), n + spent, 273);
            spent = 0;
            if (k < 257) push_step(1, k + 1);
            if (k == 255) begin
                // Same row as before: blanking only in the LATCH cycle.
                check("oe_n_o latch no row change", oe_n_o, c_BLANK);
                @(negedge clk_i);
                check("oe_n_o after latch no row change", oe_n_o, 0);
                spent += 1;
            end
            if (k == 256) begin
                check("oe_n_o latch row change", oe_n_o, c_BLANK);
                for (int i = 1; i <= 4; i++) begin
                    @(negedge clk_i);
                    check($sformatf("oe_n_o blank +%0d", i), oe_n_o, c_BLANK);
                end
                @(negedge clk_i);
                check("oe_n_o after blank", oe_n_o, 0);
                repeat (40) @(negedge clk_i);
                enable_i = 1'b0;
                spent += 45;
            end
        end

        // Enable was dropped: the engine must now sit in IDLE.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check($sformatf("idle sclk/latch/oe_n %0d", i), {sclk_o, latch_o, oe_n_o}, 3'b001);
        end
        check("bit queue drained", exp_bits.size(), 0);
        check("latch queue drained", exp_latch.size(), 0);

        for (int i = 0; i < 10000 && !mini_done; i++) @(negedge clk_i);
        if (!mini_done) fail_now("timeout waiting for small-instance checks");
        finish_tb();
    end

    initial begin
        repeat (98000) @(posedge clk_i);
        $display("FAIL watchdog: simulation cycle limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
